// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: parameter defaults, opcodes and
// the response-buffer state encoding.
package alu_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request / ALU / response bundle for alu_arbiter.
// slave  : the arbiter side.
// master : the environment side (requesters, ALU, response consumer).
interface alu_arbiter_if
    import alu_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*3-1:0] req_op;

    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [2:0]        alu_op;
    logic [W-1:0]      alu_result;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_result;
    logic              rsp_zero;

    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op,
               rsp_valid, rsp_id, rsp_result, rsp_zero
    );

    modport master (
        output req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op,
               rsp_valid, rsp_id, rsp_result, rsp_zero
    );

endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Grant picker: returns one-hot grant, grant index and found flag.
// Default is round-robin starting at i_ptr; ALU_ARB_FIXED_PRIO_EN selects
// fixed priority (lowest index wins, i_ptr ignored).
module alu_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_found
);
    logic [NREQ-1:0] w_rot;
    logic [IDW-1:0]  w_off;

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;
    assign w_rot        = i_valid;
    assign o_idx        = w_off;
`else
    logic [IDW:0] w_sum;
    // Rotate so bit 0 is the requester at i_ptr; the first set bit's offset
    // is then added back modulo NREQ.
    assign w_rot = NREQ'({i_valid, i_valid} >> i_ptr);
    assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_idx = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ))
                                             : w_sum[IDW-1:0];
`endif

    // Priority-encode the lowest set bit of the (rotated) valid vector.
    always_comb begin
        w_off   = '0;
        o_found = 1'b0;
        for (int unsigned k = 0; k < unsigned'(NREQ); k++) begin
            if (!o_found && w_rot[k]) begin
                o_found = 1'b1;
                w_off   = IDW'(k);
            end
        end
    end

    // Decode the winning index to a one-hot grant.
    always_comb begin
        o_grant = '0;
        for (int unsigned i = 0; i < unsigned'(NREQ); i++) begin
            o_grant[i] = o_found && (o_idx == IDW'(i));
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters and buffers one
// tagged result for a valid/ready consumer.
// Optional macro: ALU_ARB_FIXED_PRIO_EN (fixed priority, no rotate pointer).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  w_ptr;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_idx;
    logic            w_found;
    logic            w_slot_free;
    logic            w_accept;
    logic            w_rsp_valid;
    logic [W-1:0]    w_alu_a;
    logic [W-1:0]    w_alu_b;
    logic [2:0]      w_alu_op;
    logic [W-1:0]    w_capture;
    logic [IDW-1:0]  r_rsp_id;
    logic [W-1:0]    r_rsp_result;
    logic            r_rsp_zero;

    alu_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .i_valid (bus.req_valid),
        .i_ptr   (w_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    assign w_slot_free   = rst && ((r_state == ST_EMPTY) || bus.rsp_ready);
    assign w_accept      = w_slot_free && w_found;
    assign bus.req_ready = w_accept ? w_grant : '0;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [IDW-1:0] r_ptr;

    // Round-robin pointer: moves just past the winner on every accept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + 1'b1;
        end
    end

    assign w_ptr = r_ptr;
`endif

    // ALU operand mux: winner's operands, or a benign ADD of zeros when idle.
    always_comb begin
        w_alu_a  = '0;
        w_alu_b  = '0;
        w_alu_op = OP_ADD;
        if (w_found) begin
            for (int unsigned i = 0; i < unsigned'(NREQ); i++) begin
                if (w_idx == IDW'(i)) begin
                    w_alu_a  = bus.req_a[i*W +: W];
                    w_alu_b  = bus.req_b[i*W +: W];
                    w_alu_op = bus.req_op[i*3 +: 3];
                end
            end
        end
    end

    assign bus.alu_a  = w_alu_a;
    assign bus.alu_b  = w_alu_b;
    assign bus.alu_op = w_alu_op;

    // Undefined opcodes capture zero regardless of what the ALU returns.
    assign w_capture = (w_alu_op > OP_SLT) ? '0 : bus.alu_result;

    // Response-buffer state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: fill on accept, drain when consumed without refill.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (!w_accept && bus.rsp_ready) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        w_rsp_valid = (r_state == ST_FULL);
    end

    // Response payload: captured on accept, otherwise held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_id     <= w_idx;
            r_rsp_result <= w_capture;
            r_rsp_zero   <= (w_capture == '0);
        end
    end

    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_zero   = r_rsp_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus();

    alu_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Combinational ALU stand-in; undefined opcodes return nonzero junk.
    always_comb begin
        case (bus.alu_op)
            3'b000:  bus.alu_result = bus.alu_a & bus.alu_b;
            3'b001:  bus.alu_result = bus.alu_a | bus.alu_b;
            3'b010:  bus.alu_result = bus.alu_a + bus.alu_b;
            3'b011:  bus.alu_result = bus.alu_a - bus.alu_b;
            3'b100:  bus.alu_result = (bus.alu_a < bus.alu_b) ? 32'd1 : 32'd0;
            default: bus.alu_result = bus.alu_a ^ bus.alu_b ^ 32'hDEAD_BEEF;
        endcase
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Requester drive state.
    bit         d_v  [NREQ];
    logic [W-1:0] d_a [NREQ];
    logic [W-1:0] d_b [NREQ];
    logic [2:0] d_op [NREQ];

    // Reference model state.
    bit           m_full = 1'b0;
    int           m_ptr  = 0;
    int           m_id   = 0;
    logic [W-1:0] m_res  = '0;
    bit           m_zero = 1'b0;

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return a - b;
            3'd4:    return (a < b) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]     = d_v[i];
            bus.req_a[i*W +: W]  = d_a[i];
            bus.req_b[i*W +: W]  = d_b[i];
            bus.req_op[i*3 +: 3] = d_op[i];
        end
    endtask

    // One clock cycle: apply inputs, check combinational outputs, advance the
    // model across the edge, then check registered outputs.
    task automatic step(output int g, output logic [NREQ-1:0] obs_rdy);
        int best;
        int d;
        bit acc;
        logic [NREQ-1:0] exp_rdy;
        drive();
        #1;
        g    = -1;
        best = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (d_v[i]) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                d = i;
`else
                d = (i - m_ptr + NREQ) % NREQ;
`endif
                if (d < best) begin
                    best = d;
                    g    = i;
                end
            end
        end
        acc     = (rst === 1'b1) && (!m_full || bus.rsp_ready === 1'b1) && (g >= 0);
        exp_rdy = acc ? (NREQ'(1) << g) : '0;
        obs_rdy = bus.req_ready;
        chk("req_ready", obs_rdy, exp_rdy);
        if (rst === 1'b1) begin
            if (g >= 0) begin
                chk("alu_a", bus.alu_a, d_a[g]);
                chk("alu_b", bus.alu_b, d_b[g]);
                chk("alu_op", bus.alu_op, d_op[g]);
            end else begin
                chk("alu_a_idle", bus.alu_a, 0);
                chk("alu_b_idle", bus.alu_b, 0);
                chk("alu_op_idle", bus.alu_op, 3'b010);
            end
        end
        if (rst !== 1'b1) begin
            m_full = 0; m_ptr = 0; m_id = 0; m_res = '0; m_zero = 0;
        end else if (acc) begin
            m_res  = ref_op(d_a[g], d_b[g], d_op[g]);
            m_zero = (m_res == 0);
            m_id   = g;
            m_full = 1;
            m_ptr  = (g + 1) % NREQ;
        end else if (m_full && bus.rsp_ready === 1'b1) begin
            m_full = 0;
        end
        if (!acc) g = -1;
        @(negedge clk);
        chk("rsp_valid", bus.rsp_valid, m_full);
        chk("rsp_id", bus.rsp_id, m_id);
        chk("rsp_result", bus.rsp_result, m_res);
        chk("rsp_zero", bus.rsp_zero, m_zero);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) begin
            d_v[i] = 0; d_a[i] = '0; d_b[i] = '0; d_op[i] = 3'b010;
        end
    endtask

    initial begin
        int g;
        logic [NREQ-1:0] r;
        logic [W-1:0] oc_a [4];
        logic [W-1:0] oc_b [4];
        logic [2:0]   oc_op[4];
        logic [W-1:0] oc_res[4];
        bit           oc_z [4];
        logic [NREQ-1:0] bp_next;

        oc_a  = '{32'd9, 32'd3, 32'd0, 32'd5};
        oc_b  = '{32'd9, 32'd8, 32'd1, 32'd3};
        oc_op = '{3'b011, 3'b100, 3'b011, 3'b111};
        oc_res = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'd0};
        oc_z  = '{1'b1, 1'b0, 1'b0, 1'b1};

        clear_reqs();
        bus.rsp_ready = 1'b1;
        rst = 1'b0;
        drive();
        @(negedge clk);

        // Reset with every requester valid.
        for (int i = 0; i < NREQ; i++) begin
            d_v[i] = 1; d_a[i] = 32'(i + 1); d_b[i] = 32'd10; d_op[i] = 3'b010;
        end
        for (int k = 0; k < 2; k++) begin
            step(g, r);
            chk("rst_ready", r, 0);
            chk("rst_valid", bus.rsp_valid, 0);
            chk("rst_result", bus.rsp_result, 0);
        end
        rst = 1'b1;
        step(g, r);
        chk("first_grant", r, 4'b0001);

        // Single ADD after a fresh reset.
        rst = 1'b0;
        step(g, r);
        rst = 1'b1;
        clear_reqs();
        d_v[0] = 1; d_a[0] = 32'd5; d_b[0] = 32'd7; d_op[0] = 3'b010;
        step(g, r);
        chk("add_grant", r, 4'b0001);
        chk("add_valid", bus.rsp_valid, 1);
        chk("add_result", bus.rsp_result, 12);
        chk("add_id", bus.rsp_id, 0);
        chk("add_zero", bus.rsp_zero, 0);
        d_v[0] = 0;

        rst = 1'b0;
        step(g, r);
        rst = 1'b1;

`ifdef ALU_ARB_FIXED_PRIO_EN
        // Fixed priority: req 2 starves while req 0 stays valid.
        d_v[0] = 1; d_v[2] = 1;
        for (int k = 0; k < 10; k++) begin
            step(g, r);
            chk("fp_grant", r, 4'b0001);
        end
        d_v[0] = 0;
        step(g, r);
        chk("fp_req2", r, 4'b0100);
        bp_next = 4'b0001;
`else
        // Round-robin: all valid, one grant per cycle in rotating order.
        for (int i = 0; i < NREQ; i++) d_v[i] = 1;
        for (int k = 0; k < 6; k++) begin
            step(g, r);
            chk("rr_grant", r, NREQ'(1) << (k % NREQ));
            chk("rr_id", bus.rsp_id, k % NREQ);
        end
        bp_next = 4'b1000;
`endif

        // Backpressure: fill, stall three cycles, then drain and refill.
        for (int i = 0; i < NREQ; i++) d_v[i] = 1;
        bus.rsp_ready = 1'b1;
        step(g, r);
        if (g >= 0) d_a[g] = d_a[g] + 32'd100;
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(g, r);
            chk("bp_ready", r, 0);
            chk("bp_valid", bus.rsp_valid, 1);
        end
        bus.rsp_ready = 1'b1;
        step(g, r);
        chk("bp_refill", r, bp_next);
        chk("bp_valid_after", bus.rsp_valid, 1);

        // Opcode coverage on requester 1.
        clear_reqs();
        step(g, r);
        for (int k = 0; k < 4; k++) begin
            d_v[1] = 1; d_a[1] = oc_a[k]; d_b[1] = oc_b[k]; d_op[1] = oc_op[k];
            step(g, r);
            chk("op_result", bus.rsp_result, oc_res[k]);
            chk("op_zero", bus.rsp_zero, oc_z[k]);
            chk("op_id", bus.rsp_id, 1);
            d_v[1] = 0;
        end

        // Randomized traffic with backpressure and occasional resets.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!d_v[i] && $urandom_range(2) == 0) begin
                    d_v[i] = 1;
                    d_a[i] = $urandom;
                    case ($urandom_range(3))
                        0:       d_b[i] = d_a[i];
                        1:       d_b[i] = 32'($urandom_range(15));
                        default: d_b[i] = $urandom;
                    endcase
                    d_op[i] = 3'($urandom_range(7));
                end
            end
            bus.rsp_ready = ($urandom_range(3) != 0);
            rst = ($urandom_range(80) != 0);
            step(g, r);
            if (g >= 0) d_v[g] = 0;
        end
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `ALU` instance between up to `NREQ` requesters, such as the EX stage, a branch-compare unit and a debug port. Each requester presents operands and an opcode with a valid/ready handshake. The arbiter grants one requester per cycle, round-robin by default, and drives the ALU inputs. It registers the result in a single-entry output buffer that is tagged with the requester id and drained through a valid/ready response port.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `W`, default 32: operand and result width.
- `IDW`, default `$clog2(NREQ)`: width of the response id.
- `clk` in, 1: the only clock; all state updates on the rising edge.
- `rst` in, 1: synchronous reset, active-low; sampled on the rising edge of `clk`.
- `req_valid` in, NREQ: per-requester request valid.
- `req_ready` out, NREQ: per-requester accept; at most one bit high in any cycle.
- `req_a` in, NREQ*W: operand a; requester i occupies bits [i*W +: W].
- `req_b` in, NREQ*W: operand b, same packing as `req_a`.
- `req_op` in, NREQ*3: opcode; requester i occupies bits [i*3 +: 3].
- `alu_a` out, W: drives the ALU `a` input.
- `alu_b` out, W: drives the ALU `b` input.
- `alu_op` out, 3: drives the ALU `ALUop` input.
- `alu_result` in, W: the ALU `Result` output, combinational in the same cycle.
- `rsp_valid` out, 1: the response buffer holds a result.
- `rsp_ready` in, 1: the consumer accepts the response.
- `rsp_id` out, IDW: index of the requester that produced the result.
- `rsp_result` out, W: registered result.
- `rsp_zero` out, 1: registered flag, equal to (`rsp_result` == 0).

## Operation
- Response buffer FSM has two states.
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
- Issue condition: `slot_free` = EMPTY, or (FULL and `rsp_ready`).
- Grant selection:
  - The winner is the first requester with `req_valid` set, searching upward from `ptr` and wrapping at NREQ−1 back to 0.
  - `req_ready[g]`=1 only when `slot_free` holds and a winner exists. All other `req_ready` bits are 0.
- ALU drive:
  - `alu_a`/`alu_b`/`alu_op` are muxed from the winner whenever one exists.
  - Otherwise they are driven to 0 with op 010 (ADD), so the ALU never sees X.
- On an accept (`req_valid[g]` and `req_ready[g]`):
  - `rsp_result` ← `alu_result`, `rsp_zero` ← (`alu_result`==0), `rsp_id` ← g.
  - The FSM moves to FULL.
  - `ptr` ← (g+1) mod NREQ.
- The ALU `zero` output is not used. Its update lags `Result` by a delta, so the zero flag is recomputed locally.
- Opcodes:
  - 000 AND, 001 OR, 010 ADD (wrap mod 2^W), 011 SUB (wrap), 100 SLT (unsigned, result 1 or 0).
  - 101–111 are accepted, but the captured result is forced to 0 and `rsp_zero`=1.
- FULL with `rsp_ready`=1 and no accept: the FSM moves to EMPTY.
- FULL with `rsp_ready`=1 and an accept: drain and refill in the same edge; the FSM stays FULL.
- FULL with `rsp_ready`=0: every `req_ready` bit is 0, and `rsp_*` hold stable.
- `ptr` only advances on an accept.

## Timing
- Request accepted at edge N → `rsp_valid`=1 with that result after edge N (visible in cycle N+1).
- Throughput is one operation per cycle while `rsp_ready` stays high.
- `req_ready` depends combinationally on `req_valid`, `ptr`, FSM state and `rsp_ready`.
- Requesters must not make `req_valid` depend on `req_ready`.
- Reset, while `rst`=0 at an edge:
  - FSM → EMPTY, `ptr` → 0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_zero`=0.
  - `req_ready` is all 0 during any cycle with `rst` low.
- Reset asserted mid-operation discards a pending response without handshaking it.
- The first grant can occur in the cycle after `rst` returns high.
- A requester holds its operands and `req_valid` until it is accepted; the arbiter does not check this.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority: the lowest-indexed valid requester always wins.
  - `ptr` is not implemented.
- `ALU_ARB_FIXED_PRIO_EN` undefined (default):
  - Round-robin as described in Operation.
- All other behaviour is identical in both builds.

## Structure
- `alu_arb_pkg` holds:
  - the opcode localparams `OP_AND`, `OP_OR`, `OP_ADD`, `OP_SUB`, `OP_SLT`;
  - the FSM state encoding `ST_EMPTY`/`ST_FULL`;
  - the defaults for `NREQ` and `W`.
- One sub-module, `alu_rr_pick`, is natural. It takes valid bits and `ptr` and returns a one-hot grant, the grant index and a found flag. The fixed-priority variant lives inside it under the macro.
- The FSM, `ptr`, the response register and the ALU mux live in `alu_arbiter`.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with all `req_valid`=1 → `req_ready`=0, `rsp_valid`=0, `rsp_result`=0; the first grant after release goes to requester 0.
- Single ADD: req 0 with a=5, b=7, op=010, `rsp_ready`=1 → accepted in cycle 1; cycle 2 shows `rsp_valid`=1, `rsp_result`=12, `rsp_id`=0, `rsp_zero`=0.
- Round-robin: all 4 requesters valid continuously, `rsp_ready`=1 → grant order 0,1,2,3,0,1 at one per cycle; `rsp_id` trails the grant by one cycle.
- Backpressure: buffer FULL and `rsp_ready`=0 for 3 cycles → all `req_ready` low and `rsp_*` stable. Then raise `rsp_ready` → the response drains and the next requester is accepted on the same edge.
- Op coverage, each case checking `rsp_result`/`rsp_zero`:
  - SUB 9−9 → 0/1.
  - SLT 3,8 → 1/0.
  - SUB 0−1 → 0xFFFFFFFF/0.
  - op 111 → 0/1.
- Fixed-priority build (`ALU_ARB_FIXED_PRIO_EN`): req 0 and req 2 both held valid for 10 cycles → req 2 is never granted; after req 0 drops, req 2 is granted next cycle.
